light_monitor: RTL

- Passive checker on the two-road light bus (light1/light2, 3-bit {R,G,B} LED codes) driven by the intersection controller.
- Decodes the current phase and enforces legal phase order, no conflicting right-of-way, and phase durations counted in timebase ticks.
- Reports sticky error flags, the current phase, the last phase duration and a completed-cycle count for PS-side readback or LED debug.

---
 rtl/light_monitor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/light_monitor.sv
// Passive checker for the two-road light bus: decodes the phase, enforces order,
// conflict-freedom and phase durations, and keeps sticky error flags plus statistics.
module light_monitor #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int CYC_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [2:0]       light1,
  input  logic [2:0]       light2,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             err_seq,
  output logic             err_conflict,
  output logic             err_timing,
  output logic [7:0]       last_dur,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam logic [5:0] PAIR_OFF = 6'o00;
  localparam logic [5:0] PAIR_P0  = 6'o42;
  localparam logic [5:0] PAIR_P1  = 6'o46;
  localparam logic [5:0] PAIR_P2  = 6'o24;
  localparam logic [5:0] PAIR_P3  = 6'o64;
  localparam logic [7:0] GREEN_DUR  = 8'(GREEN_TICKS);
  localparam logic [7:0] YELLOW_DUR = 8'(YELLOW_TICKS);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_prev_pair;
  logic [1:0]       r_phase, w_phase_nxt;
  logic [7:0]       r_dur, w_dur_nxt;
  logic [7:0]       r_last, w_last_nxt;
  logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
  logic             r_first, w_first_nxt;
  logic             r_err_seq, r_err_conf, r_err_tim;
  logic             w_set_seq, w_set_tim;

  logic [5:0] w_pair;
  logic       w_change, w_is_phase, w_is_off, w_legal, w_conflict;
  logic [1:0] w_pair_phase;
  logic [7:0] w_dur_inc, w_dur_final, w_exp_dur;

  assign w_pair   = {light1, light2};
  assign w_change = (w_pair != r_prev_pair);
  assign w_is_off = (w_pair == PAIR_OFF);

  always_comb begin
    w_is_phase   = 1'b1;
    w_pair_phase = 2'd0;
    case (w_pair)
      PAIR_P0: w_pair_phase = 2'd0;
      PAIR_P1: w_pair_phase = 2'd1;
      PAIR_P2: w_pair_phase = 2'd2;
      PAIR_P3: w_pair_phase = 2'd3;
      default: w_is_phase   = 1'b0;
    endcase
  end

  assign w_legal     = w_is_phase && (w_pair_phase == r_phase + 2'd1);
  assign w_conflict  = (light1 != 3'd4) && (light1 != 3'd0) &&
                       (light2 != 3'd4) && (light2 != 3'd0);
  // A tick arriving together with the change still belongs to the old phase.
  assign w_dur_inc   = (r_dur == 8'hFF) ? r_dur : r_dur + 8'd1;
  assign w_dur_final = tick ? w_dur_inc : r_dur;
  assign w_exp_dur   = r_phase[0] ? YELLOW_DUR : GREEN_DUR;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_dur_nxt   = w_dur_final;
    w_last_nxt  = r_last;
    w_cyc_nxt   = r_cyc;
    w_first_nxt = r_first;
    w_set_seq   = 1'b0;
    w_set_tim   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dur_nxt = 8'd0;
        if (w_change) begin
          if (!w_is_phase && !w_is_off) begin
            w_set_seq = 1'b1;
          end else if (w_is_phase && (w_pair_phase == 2'd0)) begin
            w_state_nxt = S_RUN;
            w_phase_nxt = 2'd0;
            w_first_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_change) begin
          if (w_legal) begin
            w_last_nxt  = w_dur_final;
            w_set_tim   = !r_first && (w_dur_final != w_exp_dur);
            w_phase_nxt = w_pair_phase;
            w_dur_nxt   = 8'd0;
            w_first_nxt = 1'b0;
            if (r_phase == 2'd3) w_cyc_nxt = r_cyc + CYC_W'(1);
          end else begin
            w_set_seq   = 1'b1;
            w_state_nxt = S_IDLE;
            w_dur_nxt   = 8'd0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prev_pair <= PAIR_OFF;
      r_phase     <= 2'd0;
      r_dur       <= 8'd0;
      r_last      <= 8'd0;
      r_cyc       <= '0;
      r_first     <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_conf  <= 1'b0;
      r_err_tim   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_pair <= w_pair;
      r_phase     <= w_phase_nxt;
      r_dur       <= w_dur_nxt;
      r_last      <= w_last_nxt;
      r_cyc       <= w_cyc_nxt;
      r_first     <= w_first_nxt;
      // A new error event wins over a coincident clear.
      r_err_seq   <= w_set_seq  | (r_err_seq  & ~clr_err);
      r_err_conf  <= w_conflict | (r_err_conf & ~clr_err);
      r_err_tim   <= w_set_tim  | (r_err_tim  & ~clr_err);
    end
  end

  assign phase        = r_phase;
  assign phase_valid  = (r_state == S_RUN);
  assign err_seq      = r_err_seq;
  assign err_conflict = r_err_conf;
  assign err_timing   = r_err_tim;
  assign last_dur     = r_last;
  assign cycle_cnt    = r_cyc;

endmodule
